// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - standard mode timings and total helpers for vga_scan_gen
package vga_timing_pkg;

  // SVGA 800x600@60 (40 MHz pixel clock)
  localparam int SVGA_H_VISIBLE = 800;
  localparam int SVGA_H_FRONT   = 40;
  localparam int SVGA_H_SYNC    = 128;
  localparam int SVGA_H_BACK    = 88;
  localparam int SVGA_V_VISIBLE = 600;
  localparam int SVGA_V_FRONT   = 1;
  localparam int SVGA_V_SYNC    = 4;
  localparam int SVGA_V_BACK    = 23;

  // VGA 640x480@60 (25.175 MHz pixel clock)
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int SCAN_MAX_TOTAL = 65535;
  localparam int MAX_PIPE_DEPTH = 8;

  function automatic int h_total(input int visible, input int front, input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  function automatic int v_total(input int visible, input int front, input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - WIDTH x DEPTH shift register with synchronous clear; DEPTH=0 is a wire
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_nrst;
    assign unused_clk_nrst = clk ^ nrst;
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!nrst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - parametrised VGA scan/timing generator with aligned sync and registered RGB
// Optional internal grid test pattern: VGA_SCAN_TESTPAT_EN
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE   = SVGA_H_VISIBLE,
  parameter int H_FRONT     = SVGA_H_FRONT,
  parameter int H_SYNC      = SVGA_H_SYNC,
  parameter int H_BACK      = SVGA_H_BACK,
  parameter int V_VISIBLE   = SVGA_V_VISIBLE,
  parameter int V_FRONT     = SVGA_V_FRONT,
  parameter int V_SYNC      = SVGA_V_SYNC,
  parameter int V_BACK      = SVGA_V_BACK,
  parameter bit HSYNC_POL   = 1'b1,
  parameter bit VSYNC_POL   = 1'b1,
  parameter int PIPE_DEPTH  = 2,
  parameter int CHAR_W_LOG2 = 3,
  parameter int CHAR_H_LOG2 = 4,
  parameter int COLOR_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  output logic [15:0]            hcount,
  output logic [15:0]            vcount,
  output logic                   fetch_en,
  output logic [15:0]            char_col,
  output logic [15:0]            char_row,
  output logic [CHAR_W_LOG2-1:0] glyph_x,
  output logic [CHAR_H_LOG2-1:0] glyph_y,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [7:0]             frame_count,
  input  logic                   testpat,
  input  logic [COLOR_BITS-1:0]  pix_r,
  input  logic [COLOR_BITS-1:0]  pix_g,
  input  logic [COLOR_BITS-1:0]  pix_b,
  output logic [COLOR_BITS-1:0]  red,
  output logic [COLOR_BITS-1:0]  green,
  output logic [COLOR_BITS-1:0]  blue,
  output logic                   hsync,
  output logic                   vsync
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > SCAN_MAX_TOTAL || V_TOTAL > SCAN_MAX_TOTAL) begin : g_total_check
    $error("vga_scan_gen: H_TOTAL or V_TOTAL exceeds the 16-bit counter range");
  end
  if (PIPE_DEPTH < 0 || PIPE_DEPTH > MAX_PIPE_DEPTH) begin : g_depth_check
    $error("vga_scan_gen: PIPE_DEPTH must be 0..8");
  end

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] HS_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [COLOR_BITS-1:0] COLOR_MAX = '1;

  logic [15:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [7:0]  frame_count_q, frame_count_d;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = h_wrap && (vcount_q == V_LAST);
    hcount_d      = h_wrap ? 16'd0 : hcount_q + 16'd1;
    vcount_d      = vcount_q;
    if (h_wrap) vcount_d = (vcount_q == V_LAST) ? 16'd0 : vcount_q + 16'd1;
    frame_count_d = v_wrap ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_count_q <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign frame_count = frame_count_q;
  assign fetch_en    = (hcount_q < H_VIS) && (vcount_q < V_VIS);
  assign char_col    = hcount_q >> CHAR_W_LOG2;
  assign char_row    = vcount_q >> CHAR_H_LOG2;
  assign glyph_x     = hcount_q[CHAR_W_LOG2-1:0];
  assign glyph_y     = vcount_q[CHAR_H_LOG2-1:0];
  assign line_start  = (hcount_q == 16'd0);
  assign frame_start = (hcount_q == 16'd0) && (vcount_q == 16'd0);

  logic hsync_act, vsync_act;
  assign hsync_act = (hcount_q >= HS_START) && (hcount_q < HS_END);
  assign vsync_act = (vcount_q >= VS_START) && (vcount_q < VS_END);

  // Timing flags ride alongside the downstream pixel pipeline so they meet pix_* in the same cycle
`ifdef VGA_SCAN_TESTPAT_EN
  localparam int ALIGN_W = 4;
  logic on_grid;
  assign on_grid = (glyph_x == '0) || (glyph_y == '0);
`else
  localparam int ALIGN_W = 3;
`endif

  logic [ALIGN_W-1:0] align_in, align_out;
`ifdef VGA_SCAN_TESTPAT_EN
  assign align_in = {on_grid, vsync_act, hsync_act, fetch_en};
`else
  assign align_in = {vsync_act, hsync_act, fetch_en};
`endif

  vga_delay_line #(
    .WIDTH(ALIGN_W),
    .DEPTH(PIPE_DEPTH)
  ) u_align (
    .clk (clk),
    .nrst(nrst),
    .d_i (align_in),
    .q_o (align_out)
  );

  logic [COLOR_BITS-1:0] src_r, src_g, src_b;

  always_comb begin
    src_r = pix_r;
    src_g = pix_g;
    src_b = pix_b;
`ifdef VGA_SCAN_TESTPAT_EN
    if (testpat) begin
      src_r = align_out[3] ? COLOR_MAX : '0;
      src_g = align_out[3] ? COLOR_MAX : '0;
      src_b = align_out[3] ? '0 : (COLOR_MAX >> 1);
    end
`endif
  end

`ifndef VGA_SCAN_TESTPAT_EN
  logic unused_testpat;
  assign unused_testpat = testpat;
`endif

  logic [COLOR_BITS-1:0] red_q, green_q, blue_q;
  logic                  hsync_q, vsync_q;

  // Blanked pixels load 0 so nothing reaches the DAC outside the visible area
  always_ff @(posedge clk) begin
    if (!nrst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else begin
      red_q   <= align_out[0] ? src_r : '0;
      green_q <= align_out[0] ? src_g : '0;
      blue_q  <= align_out[0] ? src_b : '0;
      hsync_q <= align_out[1] ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= align_out[2] ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - scoreboard bench for vga_scan_gen in a small 24x12 mode
module tb_vga_scan_gen;

  localparam int HV = 16, HF = 2, HS = 3, HB = 3, HT = 24;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 1, VT = 12;
  localparam int PD = 2;
`ifdef VGA_SCAN_TESTPAT_EN
  localparam bit TP_BUILD = 1'b1;
`else
  localparam bit TP_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        fetch;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
    logic [15:0] cc;
    logic [15:0] cr;
    logic [2:0]  gx;
    logic [3:0]  gy;
  } coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } pin_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic testpat = 1'b0;
  logic [3:0] pix_r = '0, pix_g = '0, pix_b = '0;

  logic [15:0] hcount, vcount, char_col, char_row;
  logic        fetch_en, line_start, frame_start, hsync, vsync;
  logic [2:0]  glyph_x;
  logic [3:0]  glyph_y;
  logic [7:0]  frame_count;
  logic [3:0]  red, green, blue;

  logic [15:0] n_hcount, n_vcount, n_char_col, n_char_row;
  logic        n_fetch_en, n_line_start, n_frame_start, n_hsync, n_vsync;
  logic [2:0]  n_glyph_x;
  logic [3:0]  n_glyph_y;
  logic [7:0]  n_frame_count;
  logic [3:0]  n_red, n_green, n_blue;

  always #5 clk = ~clk;

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DEPTH(PD),
    .CHAR_W_LOG2(3), .CHAR_H_LOG2(4), .COLOR_BITS(4)
  ) u_dut (
    .clk(clk), .nrst(nrst), .hcount(hcount), .vcount(vcount), .fetch_en(fetch_en),
    .char_col(char_col), .char_row(char_row), .glyph_x(glyph_x), .glyph_y(glyph_y),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count),
    .testpat(testpat), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DEPTH(PD),
    .CHAR_W_LOG2(3), .CHAR_H_LOG2(4), .COLOR_BITS(4)
  ) u_dut_n (
    .clk(clk), .nrst(nrst), .hcount(n_hcount), .vcount(n_vcount), .fetch_en(n_fetch_en),
    .char_col(n_char_col), .char_row(n_char_row), .glyph_x(n_glyph_x), .glyph_y(n_glyph_y),
    .line_start(n_line_start), .frame_start(n_frame_start), .frame_count(n_frame_count),
    .testpat(testpat), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .red(n_red), .green(n_green), .blue(n_blue), .hsync(n_hsync), .vsync(n_vsync)
  );

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  bit tp_flag = 1'b0;
  coord_t cq[$];
  pin_t   pq[$];

  int mh, mv, mfc;
  logic [3:0] hh0, hh1, vh0, vh1;

  function automatic pin_t exp_pin(input int h, input int v, input bit tp);
    pin_t p;
    p = '0;
    p.hs = (h >= HV + HF) && (h < HV + HF + HS);
    p.vs = (v >= VV + VF) && (v < VV + VF + VS);
    if (h < HV && v < VV) begin
      if (tp && TP_BUILD) begin
        if ((h % 8) == 0 || (v % 16) == 0) begin
          p.r = 4'd15; p.g = 4'd15; p.b = 4'd0;
        end else begin
          p.r = 4'd0; p.g = 4'd0; p.b = 4'd7;
        end
      end else begin
        p.r = 4'(h % 16);
        p.g = 4'(v % 16);
        p.b = 4'hA;
      end
    end
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one cycle: drive pix_* from the modelled history, queue the expectations, advance the model
  task automatic step();
    coord_t c;
    pix_r = hh1;
    pix_g = vh1;
    pix_b = 4'hA;
    c.h = 16'(mh); c.v = 16'(mv);
    c.fetch = (mh < HV) && (mv < VV);
    c.ls = (mh == 0);
    c.fs = (mh == 0) && (mv == 0);
    c.fc = 8'(mfc);
    c.cc = 16'(mh / 8); c.cr = 16'(mv / 16);
    c.gx = 3'(mh % 8);  c.gy = 4'(mv % 16);
    cq.push_back(c);
    pq.push_back(exp_pin(mh, mv, tp_flag));
    @(posedge clk); #1;
    hh1 = hh0; hh0 = 4'(mh);
    vh1 = vh0; vh0 = 4'(mv);
    if (mh == HT - 1) begin
      mh = 0;
      if (mv == VT - 1) begin
        mv = 0;
        mfc = (mfc + 1) % 256;
      end else mv = mv + 1;
    end else mh = mh + 1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < HT * VT && !(mh == h && mv == v); i++) step();
  endtask

  task automatic do_reset(input int n);
    mon_en = 1'b0;
    nrst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_hcount", 32'(hcount), 32'd0);
    chk("rst_vcount", 32'(vcount), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_sync_pos", 32'({hsync, vsync}), 32'b00);
    chk("rst_sync_neg", 32'({n_hsync, n_vsync}), 32'b11);
    cq.delete();
    pq.delete();
    for (int i = 0; i <= PD; i++) pq.push_back(pin_t'(0));
    mh = 0; mv = 0; mfc = 0;
    hh0 = '0; hh1 = '0; vh0 = '0; vh1 = '0;
    nrst = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    coord_t c, ca;
    pin_t   p, pa;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (cq.size() == 0 || pq.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard_underflow: coord %0d pin %0d entries", cq.size(), pq.size());
        end else begin
          c = cq.pop_front();
          p = pq.pop_front();
          ca = {hcount, vcount, fetch_en, line_start, frame_start, frame_count,
                char_col, char_row, glyph_x, glyph_y};
          pa = {red, green, blue, hsync, vsync};
          tests++;
          if (ca !== c) begin
            fails++;
            $display("FAIL coords @h=%0d v=%0d: got %h expected %h", c.h, c.v, ca, c);
          end
          tests++;
          if (pa !== p) begin
            fails++;
            $display("FAIL pins: got rgb=%h/%h/%h hs=%b vs=%b expected rgb=%h/%h/%h hs=%b vs=%b",
                     pa.r, pa.g, pa.b, pa.hs, pa.vs, p.r, p.g, p.b, p.hs, p.vs);
          end
          tests++;
          if ({n_hsync, n_vsync} !== {~p.hs, ~p.vs}) begin
            fails++;
            $display("FAIL neg_pol_sync: got hs=%b vs=%b expected hs=%b vs=%b",
                     n_hsync, n_vsync, ~p.hs, ~p.vs);
          end
        end
      end
    end
  end

  initial begin
    do_reset(3);
    run(2 * HT * VT + 50);
    run_to(9, 4);
    do_reset(1);
    run(256 * HT * VT + 10);
    run_to(0, 10);
    testpat = 1'b1;
    tp_flag = 1'b1;
    run(HT * VT);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
